// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and default geometry of the imem port.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_PORTW     = 32;
    localparam int DEF_ADDRWIDTH = 7;

endpackage

// File: rtl/imem_loader.sv
// Write-side initiator for imem arbiter port 2. Takes a valid/ready stream of
// instruction words and writes them to consecutive addresses from BASE_ADDR,
// retrying any write that loses arbitration, and holds the core fetch off
// while a load is in progress.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | after reset, no load requested yet; port 2 quiet
// ST_LOAD | accepting words and writing them; core fetch held (core_lock_x=0)
// ST_DONE | all requested words written; done=1 until the next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          PORTW     = DEF_PORTW,
    parameter int          ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rstx,
    input  logic                 start,
    input  logic [ADDRWIDTH:0]   num_words,
    input  logic [PORTW-1:0]     word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic [PORTW-1:0]     d_2,
    output logic [ADDRWIDTH-1:0] addr_2,
    output logic                 en_2_x,
    output logic                 wr_2_x,
    output logic [PORTW-1:0]     bit_wr_2_x,
    input  logic                 mem_busy,
    output logic                 core_lock_x,
    output logic                 done
);

    localparam int                   CW     = ADDRWIDTH + 1;
    localparam logic [ADDRWIDTH-1:0] BASE_C = ADDRWIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]        ONE_C  = CW'(1);

    state_e               state_q,   state_d;
    logic [ADDRWIDTH-1:0] addr_q,    addr_d;
    logic [CW-1:0]        rem_q,     rem_d;     // writes still to complete
    logic [CW-1:0]        uncap_q,   uncap_d;   // words still to be accepted
    logic                 pending_q, pending_d;
    logic [PORTW-1:0]     data_q,    data_d;
    logic                 lock_q,    lock_d;
    logic                 done_q,    done_d;

    logic accept;
    logic write_ok;

    // Handshake and write-completion qualifiers; mem_busy only reacts to the
    // registered en_2_x, so feeding it into word_ready cannot form a loop.
    always_comb begin
        word_ready = (state_q == ST_LOAD) && (uncap_q != '0) && (!pending_q || !mem_busy);
        accept     = word_valid && word_ready;
        write_ok   = pending_q && !mem_busy;
    end

    // Next-state logic: load sequencing, address/count updates and word capture.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        uncap_d   = uncap_q;
        pending_d = pending_q;
        data_d    = data_q;
        lock_d    = lock_q;
        done_d    = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d    = BASE_C;
                    rem_d     = num_words;
                    uncap_d   = num_words;
                    pending_d = 1'b0;
                    if (num_words == '0) begin
                        state_d = ST_DONE;
                        lock_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        lock_d  = 1'b0;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    data_d    = word_in;
                    uncap_d   = uncap_q - ONE_C;
                    pending_d = 1'b1;
                end
                if (write_ok) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - ONE_C;
                    if (!accept) begin
                        pending_d = 1'b0;
                    end
                    if (rem_q == ONE_C) begin
                        state_d   = ST_DONE;
                        pending_d = 1'b0;
                        lock_d    = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any load in flight.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state_q   <= ST_IDLE;
            addr_q    <= BASE_C;
            rem_q     <= '0;
            uncap_q   <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            lock_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            uncap_q   <= uncap_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            lock_q    <= lock_d;
            done_q    <= done_d;
        end
    end

    // Port-2 strobes follow the pending flag directly so reset drops them at once.
    always_comb begin
        en_2_x      = !pending_q;
        wr_2_x      = !pending_q;
        bit_wr_2_x  = pending_q ? '0 : '1;
        d_2         = data_q;
        addr_2      = addr_q;
        core_lock_x = lock_q;
        done        = done_q;
    end

endmodule
